md_unit: RTL and testbench

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo issued from EX, computes over a fixed multi-cycle latency, and holds the HI/LO architectural registers. It drives `busy` to the hazard unit, which stalls an MD-class instruction in D while `start || busy`. mfhi/mflo in EX read `HI`/`LO` directly.

---
 rtl/md_unit.sv | 212 +++++++++++++++++++++
 tb/tb_md_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage; fixed-latency, result held until completion.
// Optional madd/maddu/msub/msubu accumulate ops are enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        kill,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic [63:0] hilo_s;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    return ea * eb;
  endfunction

  // Signed divide on magnitudes so the most-negative / -1 case wraps cleanly.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) begin
      q = 32'd0 - q;
    end else begin
      q = q;
    end
    if (a[31]) begin
      r = 32'd0 - r;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  assign hilo_s = {hi_q, lo_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !kill) begin
          case (md_op)
            OP_MULT: begin
              res_d   = mul_s(A, B);
              cnt_d   = MULT_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_MULTU: begin
              res_d   = mul_u(A, B);
              cnt_d   = MULT_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_DIV: begin
              res_d   = (B == 32'd0) ? hilo_s : div_s(A, B);
              cnt_d   = DIV_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_DIVU: begin
              res_d   = (B == 32'd0) ? hilo_s : div_u(A, B);
              cnt_d   = DIV_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_MTHI: begin
              hi_d = A;
            end
            OP_MTLO: begin
              lo_d = A;
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
              res_d   = hilo_s + mul_s(A, B);
              cnt_d   = MULT_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_MADDU: begin
              res_d   = hilo_s + mul_u(A, B);
              cnt_d   = MULT_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_MSUB: begin
              res_d   = hilo_s - mul_s(A, B);
              cnt_d   = MULT_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
            OP_MSUBU: begin
              res_d   = hilo_s - mul_u(A, B);
              cnt_d   = MULT_CNT;
              state_d = S_BUSY;
              busy_d  = 1'b1;
            end
`endif
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // A counter at 0 here can only come from an upset; finishing is the safe recovery.
        if (cnt_q <= 4'd1) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          cnt_d   = 4'd0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against a cycle-level behavioural model.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        kill;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec;
  int n_err;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .kill(kill), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  // Architectural result of an op: go=0 means the op does nothing.
  task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit go, output int cyc, output logic [63:0] val);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {m_hi, m_lo};
    go  = 1'b1;
    cyc = 5;
    val = acc;
    case (op)
      4'd1: val = 64'(sa * sb);
      4'd2: val = 64'(ua * ub);
      4'd3: begin
        cyc = 10;
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          val = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        cyc = 10;
        if (b != 32'd0) val = {32'(ua % ub), 32'(ua / ub)};
      end
`ifdef MD_MADD_EN
      4'd7:  val = acc + 64'(sa * sb);
      4'd8:  val = acc + 64'(ua * ub);
      4'd9:  val = acc - 64'(sa * sb);
      4'd10: val = acc - 64'(ua * ub);
`endif
      default: go = 1'b0;
    endcase
  endtask

  task automatic model_edge();
    bit go;
    int cyc;
    logic [63:0] val;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (start && !kill) begin
      if (md_op == 4'd5) m_hi = A;
      else if (md_op == 4'd6) m_lo = A;
      else begin
        compute(md_op, A, B, go, cyc, val);
        if (go) begin
          m_pend = val;
          m_left = cyc;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic k);
    start = 1'b1; md_op = op; A = a; B = b; kill = k;
    step();
    start = 1'b0; md_op = 4'd0; kill = 1'b0;
  endtask

  task automatic idle_cnt(input int n, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (busy) nbusy++;
    end
  endtask

  task automatic mid_reset();
    #1 reset = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    compare();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int nb;
    logic [3:0] op;
    logic [31:0] ra, rb;
    n_vec = 0; n_err = 0;
    m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0;
    reset = 1'b1; start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0; kill = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    idle_cnt(6, nb);
    chk("mult_busy_cycles", 32'(nb + 1), 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_hold_hi", HI, 32'hFFFFFFFF);
    idle_cnt(5, nb);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);

    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle_cnt(11, nb);
    chk("div_busy_cycles", 32'(nb + 1), 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd0, 1'b0);
    idle_cnt(11, nb);
    chk("divu0_busy_cycles", 32'(nb + 1), 32'd10);
    chk("divu0_hi", HI, 32'hFFFFFFFF);
    chk("divu0_lo", LO, 32'hFFFFFFFD);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle_cnt(10, nb);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h0);

    issue(4'd5, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h12345678);
    issue(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);

    issue(4'd7, 32'd2, 32'd3, 1'b0);
    idle_cnt(6, nb);
`ifdef MD_MADD_EN
    chk("madd_hi", HI, 32'h12345678);
    chk("madd_lo", LO, 32'h9ABCDEF6);
`else
    chk("madd_off_busy", 32'(nb), 32'd0);
    chk("madd_off_lo", LO, 32'h9ABCDEF0);
`endif

    issue(4'd3, 32'd100, 32'd7, 1'b1);
    chk("kill_busy", {31'd0, busy}, 32'd0);
    idle_cnt(3, nb);
    chk("kill_nb", 32'(nb), 32'd0);

    issue(4'd1, 32'd6, 32'd7, 1'b0);
    kill = 1'b1;
    step();
    kill = 1'b0;
    idle_cnt(5, nb);
    chk("kill_late_lo", LO, 32'd42);

    issue(4'd1, 32'd9, 32'd9, 1'b0);
    step();
    step();
    mid_reset();
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    issue(4'd1, 32'd9, 32'd9, 1'b0);
    idle_cnt(6, nb);
    chk("after_rst_cycles", 32'(nb + 1), 32'd5);
    chk("after_rst_lo", LO, 32'd81);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        op = 4'($urandom_range(0, 15));
        ra = $urandom();
        rb = $urandom();
        case ($urandom_range(0, 7))
          0: rb = 32'd0;
          1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
          2: rb = 32'($urandom_range(1, 9));
          default: ;
        endcase
        issue(op, ra, rb, ($urandom_range(0, 7) == 0));
      end
    end
    idle_cnt(12, nb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
